// File: rtl/data_mem_responder.sv
// Memory-side responder for the processor data port: a single-port RAM with
// one registered read port, host load before the run and R-region dump after it.
module data_mem_responder #(
    parameter int unsigned CORE_COUNT          = 4,
    parameter int unsigned REG_WIDTH           = 12,
    parameter int unsigned DATA_MEM_ADDR_WIDTH = 12,
    parameter int unsigned R_START_LOC         = 5,
    parameter int unsigned R_END_LOC           = 8
) (
    input  logic                                 clk,
    input  logic                                 rstN,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0]       dataMemAddr,
    input  logic                                 DataMemWrEn,
    input  logic [REG_WIDTH*CORE_COUNT-1:0]      ProcessorDataOut,
    output logic [REG_WIDTH*CORE_COUNT-1:0]      ProcessorDataIn,
    input  logic                                 done,
    output logic                                 start,
    input  logic                                 hostWrValid,
    output logic                                 hostWrReady,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0]       hostWrAddr,
    input  logic [REG_WIDTH*CORE_COUNT-1:0]      hostWrData,
    input  logic                                 hostLoadDone,
    output logic                                 hostRdValid,
    input  logic                                 hostRdReady,
    output logic [REG_WIDTH*CORE_COUNT-1:0]      hostRdData,
    output logic [DATA_MEM_ADDR_WIDTH-1:0]       hostRdAddr,
    output logic                                 rangeErr
);

    localparam int unsigned W     = REG_WIDTH * CORE_COUNT;
    localparam int unsigned AW    = DATA_MEM_ADDR_WIDTH;
    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RUN       = 3'd1;
    localparam logic [2:0] S_GET_RS    = 3'd2;
    localparam logic [2:0] S_GET_RE    = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_DUMP_RD   = 3'd5;
    localparam logic [2:0] S_DUMP_WAIT = 3'd6;

    logic [W-1:0]  mem [DEPTH];
    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [W-1:0]  rd_reg;
    logic [AW-1:0] r_start;
    logic [AW-1:0] r_end;
    logic [AW-1:0] ptr;

    logic [AW-1:0] ram_addr_c;
    logic [W-1:0]  ram_wdata_c;
    logic          ram_we_c;
    logic          ram_re_c;
    logic          range_err_c;
    logic [AW-1:0] rd_low_c;

    assign rd_low_c        = AW'(rd_reg[REG_WIDTH-1:0]);
    assign ProcessorDataIn = rd_reg;
    assign hostRdData      = rd_reg;
    assign hostRdAddr      = ptr;

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and RAM port ownership: processor in RUN, host in IDLE, FSM otherwise
    always_comb begin
        next_state  = state;
        ram_addr_c  = dataMemAddr;
        ram_wdata_c = ProcessorDataOut;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;
        range_err_c = 1'b0;
        case (state)
            S_IDLE: begin
                ram_addr_c  = hostWrAddr;
                ram_wdata_c = hostWrData;
                ram_we_c    = hostWrValid && hostWrReady;
                if (hostLoadDone) next_state = S_RUN;
            end
            S_RUN: begin
                ram_re_c = 1'b1;
                ram_we_c = DataMemWrEn;
                if (done) next_state = S_GET_RS;
            end
            S_GET_RS: begin
                ram_addr_c = AW'(R_START_LOC);
                ram_re_c   = 1'b1;
                next_state = S_GET_RE;
            end
            S_GET_RE: begin
                ram_addr_c = AW'(R_END_LOC);
                ram_re_c   = 1'b1;
                next_state = S_CHECK;
            end
            S_CHECK: begin
                if (rd_low_c < r_start) begin
                    range_err_c = 1'b1;
                    next_state  = S_IDLE;
                end else begin
                    next_state = S_DUMP_RD;
                end
            end
            S_DUMP_RD: begin
                ram_addr_c = ptr;
                ram_re_c   = 1'b1;
                next_state = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (hostRdReady) begin
                    next_state = (ptr == r_end) ? S_IDLE : S_DUMP_RD;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // RAM array has no reset so loaded contents survive a mid-run reset
    always_ff @(posedge clk) begin
        if (ram_we_c) mem[ram_addr_c] <= ram_wdata_c;
    end

    // Read register, R bounds, dump pointer and registered status outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_reg      <= '0;
            r_start     <= '0;
            r_end       <= '0;
            ptr         <= '0;
            start       <= 1'b0;
            hostWrReady <= 1'b0;
            hostRdValid <= 1'b0;
            rangeErr    <= 1'b0;
        end else begin
            start       <= (next_state == S_RUN);
            hostWrReady <= (next_state == S_IDLE);
            hostRdValid <= (next_state == S_DUMP_WAIT);
            rangeErr    <= range_err_c;
            if (ram_re_c) rd_reg <= mem[ram_addr_c];
            if (state == S_GET_RE) r_start <= rd_low_c;
            if (state == S_CHECK) begin
                r_end <= rd_low_c;
                ptr   <= r_start;
            end
            if (state == S_DUMP_WAIT && hostRdReady && ptr != r_end) begin
                ptr <= ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a sparse
// memory model and the cycle-level protocol rules of the host and processor ports.
module tb_data_mem_responder;

    localparam int W = 48;
    localparam int A = 12;

    logic         clk = 1'b0;
    logic         rstN;
    logic [A-1:0] dataMemAddr;
    logic         DataMemWrEn;
    logic [W-1:0] ProcessorDataOut;
    logic [W-1:0] ProcessorDataIn;
    logic         done;
    logic         start;
    logic         hostWrValid;
    logic         hostWrReady;
    logic [A-1:0] hostWrAddr;
    logic [W-1:0] hostWrData;
    logic         hostLoadDone;
    logic         hostRdValid;
    logic         hostRdReady;
    logic [W-1:0] hostRdData;
    logic [A-1:0] hostRdAddr;
    logic         rangeErr;

    data_mem_responder dut (
        .clk(clk), .rstN(rstN),
        .dataMemAddr(dataMemAddr), .DataMemWrEn(DataMemWrEn),
        .ProcessorDataOut(ProcessorDataOut), .ProcessorDataIn(ProcessorDataIn),
        .done(done), .start(start),
        .hostWrValid(hostWrValid), .hostWrReady(hostWrReady),
        .hostWrAddr(hostWrAddr), .hostWrData(hostWrData),
        .hostLoadDone(hostLoadDone),
        .hostRdValid(hostRdValid), .hostRdReady(hostRdReady),
        .hostRdData(hostRdData), .hostRdAddr(hostRdAddr),
        .rangeErr(rangeErr)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ref_mem [int];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd48();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int addr, input logic [W-1:0] d);
        chk("wr_ready", 64'(hostWrReady), 64'(1));
        hostWrValid = 1'b1;
        hostWrAddr  = A'(addr);
        hostWrData  = d;
        step();
        hostWrValid = 1'b0;
        ref_mem[addr] = d;
    endtask

    task automatic launch();
        hostLoadDone = 1'b1;
        step();
        hostLoadDone = 1'b0;
        chk("start_rise", 64'(start), 64'(1));
    endtask

    // One RUN cycle: data read is the memory content before this cycle's write
    task automatic proc_cycle(input int addr, input bit we, input logic [W-1:0] d);
        dataMemAddr      = A'(addr);
        DataMemWrEn      = we;
        ProcessorDataOut = d;
        step();
        if (ref_mem.exists(addr)) chk("proc_rd", 64'(ProcessorDataIn), 64'(ref_mem[addr]));
        if (we) ref_mem[addr] = d;
        DataMemWrEn = 1'b0;
    endtask

    task automatic set_range(input int rs, input int re);
        host_write(5, {W'(rnd48()) >> 12, 12'(rs)});
        host_write(8, {W'(rnd48()) >> 12, 12'(rs == re ? re : re)});
    endtask

    // Raise done from RUN, then expect either a range error or the full dump
    task automatic run_dump(input int rs, input int re, input int stall_idx,
                            input int stall_len, input bit poke_load);
        int cnt;
        dataMemAddr = '0;
        done = 1'b1;
        step();
        done = 1'b0;
        chk("start_fall", 64'(start), 64'(0));
        if (re < rs) begin
            step();
            step();
            chk("err_early", 64'(rangeErr), 64'(0));
            step();
            chk("err_pulse", 64'(rangeErr), 64'(1));
            chk("err_novalid", 64'(hostRdValid), 64'(0));
            step();
            chk("err_clear", 64'(rangeErr), 64'(0));
            chk("err_idle", 64'(hostWrReady), 64'(1));
            chk("err_novalid2", 64'(hostRdValid), 64'(0));
        end else begin
            cnt = 0;
            while (!hostRdValid && cnt < 10) begin
                step();
                cnt++;
            end
            chk("first_lat", 64'(cnt), 64'(4));
            for (int i = 0; i <= re - rs; i++) begin
                if (i > 0) begin
                    chk("gap", 64'(hostRdValid), 64'(0));
                    step();
                    chk("valid", 64'(hostRdValid), 64'(1));
                end
                chk("dump_data", 64'(hostRdData), 64'(ref_mem[rs + i]));
                chk("dump_addr", 64'(hostRdAddr), 64'(rs + i));
                if (i == stall_idx) begin
                    for (int s = 0; s < stall_len; s++) begin
                        hostLoadDone = poke_load;
                        step();
                        chk("stall_valid", 64'(hostRdValid), 64'(1));
                        chk("stall_data", 64'(hostRdData), 64'(ref_mem[rs + i]));
                        chk("stall_addr", 64'(hostRdAddr), 64'(rs + i));
                        chk("stall_nostart", 64'(start), 64'(0));
                    end
                    hostLoadDone = 1'b0;
                end
                hostRdReady = 1'b1;
                step();
                hostRdReady = 1'b0;
            end
            chk("dump_end_valid", 64'(hostRdValid), 64'(0));
            chk("dump_end_idle", 64'(hostWrReady), 64'(1));
            chk("dump_end_start", 64'(start), 64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v;
        int rs, len, cnt;

        rstN = 1'b0;
        dataMemAddr = '0; DataMemWrEn = 1'b0; ProcessorDataOut = '0; done = 1'b0;
        hostWrValid = 1'b0; hostWrAddr = '0; hostWrData = '0; hostLoadDone = 1'b0;
        hostRdReady = 1'b0;
        step();
        step();
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_valid", 64'(hostRdValid), 64'(0));
        chk("rst_err", 64'(rangeErr), 64'(0));
        chk("rst_pdi", 64'(ProcessorDataIn), 64'(0));
        chk("rst_rdaddr", 64'(hostRdAddr), 64'(0));
        rstN = 1'b1;
        step();
        chk("rst_idle", 64'(hostWrReady), 64'(1));

        // Load and launch, with ignored processor inputs while idle
        host_write(0, 48'd3);
        host_write(1, 48'd2);
        host_write(2, 48'd4);
        for (int a = 'h200; a < 'h210; a++) host_write(a, rnd48());
        set_range('h020, 'h023);
        DataMemWrEn = 1'b1; dataMemAddr = A'('h200); ProcessorDataOut = rnd48(); done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_nostart", 64'(start), 64'(0));
            chk("idle_stay", 64'(hostWrReady), 64'(1));
            chk("idle_noerr", 64'(rangeErr), 64'(0));
        end
        DataMemWrEn = 1'b0; done = 1'b0;
        v = rnd48();
        hostWrValid = 1'b1; hostWrAddr = A'(9); hostWrData = v;
        launch();
        hostWrValid = 1'b0;
        ref_mem[9] = v;
        chk("run_notready", 64'(hostWrReady), 64'(0));

        proc_cycle(0, 1'b0, '0);
        proc_cycle(1, 1'b0, '0);
        proc_cycle(2, 1'b0, '0);
        proc_cycle(9, 1'b0, '0);
        proc_cycle('h200, 1'b0, '0);
        proc_cycle('h100, 1'b1, 48'hABC1_2345_6789);
        proc_cycle('h100, 1'b0, '0);
        proc_cycle('h100, 1'b1, 48'h1111_2222_3333);
        proc_cycle('h100, 1'b0, '0);
        for (int k = 0; k < 40; k++) begin
            proc_cycle('h200 + int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rnd48());
        end
        for (int a = 'h020; a <= 'h023; a++) proc_cycle(a, 1'b1, rnd48());
        run_dump('h020, 'h023, 1, 5, 1'b1);

        // Single-word dump with the host ready immediately
        set_range('h040, 'h040);
        host_write('h040, rnd48());
        launch();
        run_dump('h040, 'h040, -1, 0, 1'b0);

        // Range error
        set_range('h050, 'h04F);
        launch();
        run_dump('h050, 'h04F, -1, 0, 1'b0);

        // Random dumps with random stalls
        for (int it = 0; it < 3; it++) begin
            rs  = 'h300 + int'($urandom_range(0, 8));
            len = int'($urandom_range(1, 4));
            for (int a = rs; a < rs + len; a++) host_write(a, rnd48());
            set_range(rs, rs + len - 1);
            launch();
            proc_cycle(rs, 1'b0, '0);
            run_dump(rs, rs + len - 1, int'($urandom_range(0, len - 1)),
                     int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset in the middle of a dump
        for (int a = 'h060; a <= 'h062; a++) host_write(a, rnd48());
        set_range('h060, 'h062);
        launch();
        done = 1'b1;
        step();
        done = 1'b0;
        cnt = 0;
        while (!hostRdValid && cnt < 10) begin
            step();
            cnt++;
        end
        chk("mid_valid", 64'(hostRdValid), 64'(1));
        step();
        rstN = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(hostRdValid), 64'(0));
        chk("mid_rst_data", 64'(hostRdData), 64'(0));
        chk("mid_rst_addr", 64'(hostRdAddr), 64'(0));
        chk("mid_rst_pdi", 64'(ProcessorDataIn), 64'(0));
        chk("mid_rst_start", 64'(start), 64'(0));
        chk("mid_rst_err", 64'(rangeErr), 64'(0));
        step();
        rstN = 1'b1;
        step();
        chk("mid_rel_idle", 64'(hostWrReady), 64'(1));
        chk("mid_rel_valid", 64'(hostRdValid), 64'(0));
        launch();
        foreach (ref_mem[a]) proc_cycle(a, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Synthesizable memory-side responder for the multi-core processor's data-memory port, replacing the behavioural memory model used in simulation. It holds the shared data memory of `CORE_COUNT*REG_WIDTH`-bit words and answers processor reads and writes with one-cycle registered latency. A host port loads the memory before the run, raises `start`, and streams the R matrix region back out once the processor asserts `done`.

## Interface
- `CORE_COUNT`, 4, number of cores; sets the word width.
- `REG_WIDTH`, 12, per-core register width.
- `DATA_MEM_ADDR_WIDTH`, 12, address width; depth is `2**DATA_MEM_ADDR_WIDTH`.
- `R_START_LOC`, 5, address whose low `REG_WIDTH` bits hold the R start address.
- `R_END_LOC`, 8, address whose low `REG_WIDTH` bits hold the R end address.

Let `W = REG_WIDTH*CORE_COUNT` and `A = DATA_MEM_ADDR_WIDTH`.

- `clk`  in  1  single clock, rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `dataMemAddr`  in  A  processor address.
- `DataMemWrEn`  in  1  processor write enable.
- `ProcessorDataOut`  in  W  processor write data.
- `ProcessorDataIn`  out  W  registered read data to the processor.
- `done`  in  1  processor completion.
- `start`  out  1  processor start.
- `hostWrValid`  in  1  host load word valid.
- `hostWrReady`  out  1  load accepted.
- `hostWrAddr`  in  A  load address.
- `hostWrData`  in  W  load data.
- `hostLoadDone`  in  1  loading finished; launch the run.
- `hostRdValid`  out  1  dump word valid.
- `hostRdReady`  in  1  host accepts the dump word.
- `hostRdData`  out  W  dump word.
- `hostRdAddr`  out  A  address of the dump word.
- `rangeErr`  out  1  one-cycle pulse when the R end address is below the R start address.

## Operation
- The memory is a single-port synchronous RAM. It has one read-data register `rdReg`, which feeds both `ProcessorDataIn` and `hostRdData`.
- The RAM port is owned by the processor in RUN. In every other state it is owned by the FSM or the host.
- Processor writes outside RUN are ignored.
- FSM states: IDLE, RUN, GET_RS, GET_RE, CHECK, DUMP_RD, DUMP_WAIT.
- **IDLE** (reset state):
  - `hostWrReady=1`; a write is performed on `hostWrValid`.
  - On `hostLoadDone` go to RUN. A write in the same cycle is still performed.
- **RUN**:
  - `start=1`.
  - Each cycle: `rdReg<=mem[dataMemAddr]`, and if `DataMemWrEn`, `mem[dataMemAddr]<=ProcessorDataOut`. On simultaneous read and write to the same address, `rdReg` gets the old data.
  - On `done` go to GET_RS. A write in the `done` cycle is performed.
- **GET_RS**: read `R_START_LOC`; go to GET_RE.
- **GET_RE**:
  - Capture `rStart=rdReg[REG_WIDTH-1:0]` (zero-extended or truncated to A).
  - Read `R_END_LOC`; go to CHECK.
- **CHECK**:
  - Capture `rEnd` the same way.
  - If `rEnd<rStart`: pulse `rangeErr` and go to IDLE.
  - Otherwise set `ptr=rStart` and go to DUMP_RD.
- **DUMP_RD**: read `mem[ptr]`; go to DUMP_WAIT.
- **DUMP_WAIT**:
  - `hostRdValid=1`, `hostRdData=rdReg`, `hostRdAddr=ptr`; data is held stable until accepted.
  - On `hostRdReady`: if `ptr==rEnd` go to IDLE, else `ptr<=ptr+1` and go to DUMP_RD.
- `ptr` never wraps, because `rEnd>=rStart` is guaranteed by CHECK.
- `start` deasserts when RUN is left. `done` is ignored outside RUN.
- `hostLoadDone` outside IDLE is ignored. `hostWrValid` outside IDLE is not accepted (`hostWrReady=0`).

## Timing
- Reset values: `start=0`, `hostWrReady` reflects IDLE (1 once `rstN` is high), `hostRdValid=0`, `rangeErr=0`, `ProcessorDataIn=0`, `hostRdData=0`, `hostRdAddr=0`, state IDLE. RAM contents are not cleared.
- Reset asserted mid-operation aborts immediately. Any dump in progress is lost, and writes already done stay in memory.
- Processor read latency: address at edge N gives data valid after edge N+1. This matches the processor's memory timing.
- `start` rises on the edge after `hostLoadDone` is sampled.
- The first `hostRdValid` rises exactly 4 edges after the edge that samples `done`.
- Dump throughput is one word per 2 cycles with `hostRdReady` held high. Between words `hostRdValid` is low for exactly 1 cycle.
- A `rangeErr` pulse occurs 3 edges after `done` is sampled. The FSM is back in IDLE the next cycle.

## Test plan
- **Load and launch:** host writes `mem[0..2]` = 3, 2, 4, then asserts `hostLoadDone` together with one final write to address 9 → all four words are in memory; `start=1` one edge later.
- **Processor R/W:** in RUN, write `0xABC_123_456_789` to address 0x100, then read 0x100 → `ProcessorDataIn` returns the value 1 cycle after the read address. Also drive read and write to the same address in one cycle → `rdReg` gets the old data.
- **Dump:** set `mem[5]` low bits to 0x020 and `mem[8]` to 0x023, assert `done` → exactly 4 words stream out, at addresses 0x020–0x023. The first valid appears 4 edges after `done`. Hold `hostRdReady` low for 5 cycles on word 2 → data and address stay stable.
- **Single word and error:** with `rStart=rEnd=0x040`, exactly one word is dumped. With `rStart=0x050` and `rEnd=0x04F`, `rangeErr` pulses, no `hostRdValid` is raised, and the FSM returns to IDLE.
- **Ignored inputs:** `DataMemWrEn` in IDLE, `done` in IDLE, and `hostLoadDone` during a dump → no memory change and no state change.
- **Reset mid-dump:** pull `rstN` low during DUMP_WAIT → outputs go immediately to their reset values. After release the FSM is in IDLE and loaded memory is intact.
